// File: rtl/jam_pkg.sv
// Shared types and helpers for the exhaustive job-assignment search engine.
// Holds the FSM state encoding, search-mode constants and the factorial used for sizing checks.
package jam_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    NEXT = 2'd2,
    DONE = 2'd3
  } jam_state_e;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic longint unsigned factorial(input int n);
    longint unsigned f;
    f = 64'd1;
    for (int i = 2; i <= n; i++) begin
      f = f * 64'(i);
    end
    return f;
  endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic next-permutation of N packed IW-bit job indices.
// Only constant (loop) indices are used, so the logic maps to plain compare/mux trees.
module jam_next_perm #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N*IW-1:0] perm,
  output logic [N*IW-1:0] nxt,
  output logic            is_last
);

  logic          found;
  int            piv;
  int            succ;
  logic [IW-1:0] pval;
  logic [IW-1:0] sval;

  always_comb begin
    found = 1'b0;
    piv   = 0;
    pval  = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm[i*IW +: IW] < perm[(i+1)*IW +: IW]) begin
        found = 1'b1;
        piv   = i;
        pval  = perm[i*IW +: IW];
      end
    end

    // The suffix right of the pivot is descending, so the rightmost larger
    // element is also the smallest larger one.
    succ = 0;
    sval = '0;
    for (int j = 0; j < N; j++) begin
      if ((j > piv) && (perm[j*IW +: IW] > pval)) begin
        succ = j;
        sval = perm[j*IW +: IW];
      end
    end

    nxt = perm;
    for (int k = 0; k < N; k++) begin
      if (k == piv) begin
        nxt[k*IW +: IW] = sval;
      end else if (k > piv) begin
        for (int m = 0; m < N; m++) begin
          if (m == N + piv - k) begin
            nxt[k*IW +: IW] = (m == succ) ? pval : perm[m*IW +: IW];
          end
        end
      end
    end

    if (!found) begin
      nxt = perm;
    end
    is_last = ~found;
  end

endmodule

// File: rtl/jam_perm_search.sv
// Exhaustive N-worker/N-job assignment search over a combinational cost ROM.
// Walks every permutation in lexicographic order and tracks best total, tie count and first optimum.
module jam_perm_search
  import jam_pkg::*;
#(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int CNT_W  = 16,
  parameter int IW     = (N <= 2) ? 1 : $clog2(N),
  parameter int SUM_W  = COST_W + $clog2(N) + 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              MODE,
  output logic              BUSY,
  output logic [IW-1:0]     W,
  output logic [IW-1:0]     J,
  input  logic [COST_W-1:0] Cost,
  output logic              Valid,
  output logic [SUM_W-1:0]  MinCost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic [N*IW-1:0]   BestPerm,
  output logic [1:0]        StateDbg
);

  // Handshake: START is a level request sampled only in IDLE; BUSY is high from
  // the next cycle through DONE; Valid is a one-cycle result pulse with no
  // back-pressure, and results hold until the next accepted START.

  if ((N < 2) || (N > 8) || (factorial(N) > ((64'd1 << CNT_W) - 64'd1))) begin : g_param_chk
    $error("jam_perm_search: N must be 2..8 and CNT_W must hold N!");
  end

  function automatic logic [N*IW-1:0] ident_perm();
    logic [N*IW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[i*IW +: IW] = IW'(i);
    end
    return v;
  endfunction

  localparam logic [N*IW-1:0] IDENT = ident_perm();

  jam_state_e        state_q;
  jam_state_e        state_d;
  logic              mode_q;
  logic [IW-1:0]     w_q;
  logic [N*IW-1:0]   perm_q;
  logic [SUM_W-1:0]  acc_q;
  logic [SUM_W-1:0]  best_q;
  logic [CNT_W-1:0]  count_q;
  logic [N*IW-1:0]   bperm_q;

  logic [N*IW-1:0]   perm_nxt;
  logic              perm_is_last;
  logic              last_w;
  logic              better;
  logic              equal;
  logic [IW-1:0]     j_sel;

  jam_next_perm #(
    .N  (N),
    .IW (IW)
  ) u_next_perm (
    .perm    (perm_q),
    .nxt     (perm_nxt),
    .is_last (perm_is_last)
  );

  assign last_w = (w_q == IW'(N - 1));
  assign better = (mode_q == MODE_MAX) ? (acc_q > best_q) : (acc_q < best_q);
  assign equal  = (acc_q == best_q);

  always_comb begin
    j_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (w_q == IW'(i)) begin
        j_sel = perm_q[i*IW +: IW];
      end
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = RD;
      RD:      if (last_w) state_d = NEXT;
      NEXT:    state_d = perm_is_last ? DONE : RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    BUSY  = (state_q != IDLE);
    Valid = (state_q == DONE);
    W     = '0;
    J     = '0;
    if (state_q == RD) begin
      W = w_q;
      J = j_sel;
    end
  end

  // Datapath: worker counter, accumulator and best/count/first-optimum registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q  <= MODE_MIN;
      w_q     <= '0;
      perm_q  <= IDENT;
      acc_q   <= '0;
      best_q  <= '0;
      count_q <= '0;
      bperm_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            mode_q  <= MODE;
            w_q     <= '0;
            perm_q  <= IDENT;
            acc_q   <= '0;
            best_q  <= (MODE == MODE_MIN) ? {SUM_W{1'b1}} : {SUM_W{1'b0}};
            count_q <= '0;
            // Identity as the starting optimum keeps BestPerm right when the
            // very first permutation only ties the initial max-mode best of 0.
            bperm_q <= IDENT;
          end
        end
        RD: begin
          acc_q <= acc_q + SUM_W'(Cost);
          w_q   <= last_w ? '0 : w_q + 1'b1;
        end
        NEXT: begin
          if (better) begin
            best_q  <= acc_q;
            count_q <= CNT_W'(1);
            bperm_q <= perm_q;
          end else if (equal) begin
            count_q <= count_q + 1'b1;
          end
          if (!perm_is_last) begin
            perm_q <= perm_nxt;
          end
          acc_q <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign MinCost    = best_q;
  assign MatchCount = count_q;
  assign BestPerm   = bperm_q;
  assign StateDbg   = state_q;

endmodule

// File: tb/tb_jam_perm_search.sv
// Directed scoreboard bench for jam_perm_search at N=4 with a combinational cost ROM model.
// Driver pushes hand-computed results; a negedge monitor pops them whenever Valid is seen.
module tb_jam_perm_search;

  localparam int N       = 4;
  localparam int COST_W  = 7;
  localparam int CNT_W   = 16;
  localparam int IW      = 2;
  localparam int SUM_W   = COST_W + 2 + 1;
  localparam int PW      = N * IW;
  localparam int NPERM   = 24;
  localparam int RUN_CYC = 1 + NPERM * (N + 1);
  localparam int BUDGET  = 300;
  localparam int EXP_W   = 32 + SUM_W + CNT_W + PW;

  localparam logic [PW-1:0] P_IDENT = 8'hE4;  // 0,1,2,3
  localparam logic [PW-1:0] P_DER   = 8'hB1;  // 1,0,3,2
  localparam logic [PW-1:0] P_REV   = 8'h1B;  // 3,2,1,0

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              START;
  logic              MODE;
  logic              BUSY;
  logic [IW-1:0]     W;
  logic [IW-1:0]     J;
  logic [COST_W-1:0] Cost;
  logic              Valid;
  logic [SUM_W-1:0]  MinCost;
  logic [CNT_W-1:0]  MatchCount;
  logic [PW-1:0]     BestPerm;
  logic [1:0]        StateDbg;

  logic [COST_W-1:0] cost_m [N][N];
  logic [EXP_W-1:0]  exp_q[$];
  int                cyc = 0;
  int                n_checks = 0;
  int                n_fail = 0;

  // clock / reset
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual time %0t required < 200000", $time);
    $fatal(1, "watchdog expired");
  end

  jam_perm_search #(
    .N      (N),
    .COST_W (COST_W),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .MODE       (MODE),
    .BUSY       (BUSY),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .Valid      (Valid),
    .MinCost    (MinCost),
    .MatchCount (MatchCount),
    .BestPerm   (BestPerm),
    .StateDbg   (StateDbg)
  );

  assign Cost = cost_m[W][J];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // kind 0: all ones, 1: diag 0 / else 5, 2: w*j, 3: all 127
  task automatic load_matrix(input int kind);
    for (int w = 0; w < N; w++) begin
      for (int j = 0; j < N; j++) begin
        case (kind)
          0:       cost_m[w][j] = 7'd1;
          1:       cost_m[w][j] = (w == j) ? 7'd0 : 7'd5;
          2:       cost_m[w][j] = COST_W'(w * j);
          default: cost_m[w][j] = 7'd127;
        endcase
      end
    end
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin : monitor
    logic [EXP_W-1:0] e;
    if (RST_N && Valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("valid_cycle", 64'(cyc), 64'(e[EXP_W-1 -: 32]));
        check("min_cost", 64'(MinCost), 64'(e[PW+CNT_W +: SUM_W]));
        check("match_count", 64'(MatchCount), 64'(e[PW +: CNT_W]));
        check("best_perm", 64'(BestPerm), 64'(e[PW-1:0]));
      end
    end
  end

  // driver
  task automatic run_search(input logic mode, input logic [SUM_W-1:0] e_cost,
                            input logic [CNT_W-1:0] e_cnt, input logic [PW-1:0] e_perm,
                            input bit disturb, input bit poke_done);
    int t;
    bit seen;
    bit busy_ok;
    @(negedge CLK);
    START = 1'b1;
    MODE  = mode;
    t     = cyc;
    exp_q.push_back({32'(t + RUN_CYC), e_cost, e_cnt, e_perm});
    @(negedge CLK);
    START   = 1'b0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    for (int k = 0; k < BUDGET; k++) begin
      if (!BUSY) busy_ok = 1'b0;
      if (Valid) begin
        seen = 1'b1;
        break;
      end
      if (disturb && k == 10) begin
        START = 1'b1;
        MODE  = ~mode;
      end
      if (disturb && k == 11) START = 1'b0;
      if (disturb && k == 70) START = 1'b1;
      if (disturb && k == 72) START = 1'b0;
      @(negedge CLK);
    end
    check("busy_throughout", 64'(busy_ok), 64'd1);
    if (!seen) begin
      check("valid_timeout", 64'd0, 64'd1);
      void'(exp_q.pop_back());
    end
    if (poke_done) START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("valid_one_cycle", 64'(Valid), 64'd0);
    check("idle_after_done", 64'(BUSY), 64'd0);
    check("result_holds", 64'(MinCost), 64'(e_cost));
  endtask

  task automatic reset_mid_run();
    load_matrix(0);
    @(negedge CLK);
    START = 1'b1;
    MODE  = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    repeat (30) @(negedge CLK);
    check("busy_before_abort", 64'(BUSY), 64'd1);
    check("partial_cost_before_abort", 64'(MinCost), 64'd4);
    RST_N = 1'b0;
    #1;
    check("abort_min_cost", 64'(MinCost), 64'd0);
    check("abort_match_count", 64'(MatchCount), 64'd0);
    check("abort_best_perm", 64'(BestPerm), 64'd0);
    check("abort_busy_valid", 64'({BUSY, Valid}), 64'd0);
    check("abort_w_j", 64'({W, J}), 64'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    MODE  = 1'b0;
    load_matrix(0);
    repeat (3) @(negedge CLK);
    check("rst_min_cost", 64'(MinCost), 64'd0);
    check("rst_match_count", 64'(MatchCount), 64'd0);
    check("rst_best_perm", 64'(BestPerm), 64'd0);
    check("rst_busy_valid", 64'({BUSY, Valid}), 64'd0);
    check("rst_w_j", 64'({W, J}), 64'd0);
    check("rst_state", 64'(StateDbg), 64'd0);
    RST_N = 1'b1;

    load_matrix(0);
    run_search(1'b0, 10'd4, 16'd24, P_IDENT, 1'b0, 1'b0);
    load_matrix(1);
    run_search(1'b0, 10'd0, 16'd1, P_IDENT, 1'b0, 1'b0);
    run_search(1'b1, 10'd20, 16'd9, P_DER, 1'b0, 1'b0);
    load_matrix(2);
    run_search(1'b0, 10'd4, 16'd1, P_REV, 1'b0, 1'b1);
    load_matrix(3);
    run_search(1'b1, 10'd508, 16'd24, P_IDENT, 1'b0, 1'b0);
    load_matrix(2);
    run_search(1'b1, 10'd14, 16'd1, P_IDENT, 1'b0, 1'b1);
    load_matrix(1);
    run_search(1'b0, 10'd0, 16'd1, P_IDENT, 1'b1, 1'b0);

    reset_mid_run();
    load_matrix(1);
    run_search(1'b1, 10'd20, 16'd9, P_DER, 1'b0, 1'b0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jam_perm_search.md
# jam_perm_search

Parametrised exhaustive job-assignment search engine, the next generation of the fixed 8x8 JAM block. It enumerates every permutation of N jobs onto N workers in lexicographic order and fetches each worker/job cost from an external combinational cost ROM. Per run it reports the best total cost, the number of permutations that achieve it, and the first optimal assignment. Adds a START/BUSY handshake, min/max search mode and best-permutation output. It sits between the testbench/host controller and the cost ROM.

## Interface
- N, default 8: workers = jobs, legal 2..8.
- COST_W, default 7: width of one cost entry.
- IW, derived: $clog2(N), minimum 1.
- SUM_W, derived: COST_W + $clog2(N) + 1.
- CNT_W, default 16: MatchCount width; must hold N!, checked at elaboration.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  run request, sampled in IDLE only.
- MODE  in  1  0 = minimise, 1 = maximise; latched with START.
- BUSY  out  1  high from the cycle after START is accepted through the DONE cycle.
- W  out  IW  worker index to the cost ROM.
- J  out  IW  job index to the cost ROM.
- Cost  in  COST_W  ROM data for (W,J), valid in the same cycle (combinational ROM).
- Valid  out  1  one-cycle result pulse.
- MinCost  out  SUM_W  best total cost (minimum or maximum per MODE).
- MatchCount  out  CNT_W  number of permutations with total equal to MinCost.
- BestPerm  out  N*IW  lexicographically first optimal assignment; job for worker i at [i*IW +: IW].

## Operation
- Reset values: all outputs 0; state IDLE; perm = identity; accumulators 0.
- IDLE: START=1 latches MODE. perm := identity; best := all-ones (min) or 0 (max); count := 0. Next state RD.
- RD: lasts N cycles, w = 0..N-1. W = w, J = perm[w]. sum += Cost. On w = N-1, the full sum, including the current Cost, is registered and the FSM goes to NEXT.
- NEXT: one cycle. Compares the registered sum with best:
  - Strictly better (< for min, > for max): best := sum, count := 1, BestPerm := perm.
  - Equal: count += 1, BestPerm unchanged.
  - Worse: no change.
  - Then perm advances by the standard next-permutation rule: pivot = rightmost i with perm[i] < perm[i+1]; swap with the smallest larger element to its right; reverse the suffix.
  - If perm was descending (the last permutation), go to DONE without advancing; otherwise go to RD.
- DONE: one cycle. Valid = 1; MinCost, MatchCount and BestPerm present the final values. Next state IDLE.
- Results hold after DONE until the next accepted START. Valid drops after the DONE cycle.
- W and J are driven in every state. Outside RD they are 0.
- No overflow: SUM_W covers N*(2^COST_W-1), and CNT_W covers N!.
- START or MODE changes while BUSY are ignored.
- RST_N low at any time aborts the run and restores reset values asynchronously. No partial result is reported.

## Timing
- START accepted at cycle t puts RD at cycle t+1.
- Each permutation costs N+1 cycles (N in RD, 1 in NEXT).
- DONE, with Valid high, is at cycle t+1+N!*(N+1). For N=8 that is t+362881; for N=3, t+25.
- START asserted in the DONE cycle is ignored. START in the following IDLE cycle is accepted, giving a 1-cycle minimum gap between runs.
- Cost is never registered before use. The ROM path plus the adder is a single-cycle combinational path.

## Structure
- Shared package jam_pkg holds:
  - The state enum (IDLE, RD, NEXT, DONE).
  - MODE_MIN / MODE_MAX constants.
  - A factorial function for the CNT_W elaboration check.
- Sub-module jam_next_perm: purely combinational, parameter N. Input is the packed perm; outputs are the next perm and an is_last flag.
- Top-level jam_perm_search holds the FSM, the worker counter, the accumulator and the best/count/BestPerm registers.

## Test plan
- N=3, all costs 1, MODE=0 -> MinCost=3, MatchCount=6, BestPerm={0,1,2}, Valid at t+25.
- N=4, cost 0 on the diagonal and 5 elsewhere, MODE=0 -> MinCost=0, MatchCount=1, BestPerm identity.
- Same matrix, MODE=1 -> MinCost=20, MatchCount=9 (derangements), BestPerm = W0..W3 -> 1,0,3,2.
- N=8, random 7-bit costs, 3 seeds -> matches the golden model; Valid exactly at t+362881 and high for one cycle; BUSY high throughout.
- Pulse START and toggle MODE mid-run -> no effect on the result. Assert RST_N low mid-run -> all outputs 0 immediately. A new START then runs a clean search with the correct result.
- Two back-to-back runs with different matrices -> second result is independent of the first; START in the DONE cycle is ignored.
